alu_issue_stage: RTL and testbench

//  ID->EX pipeline register directly upstream of the ALU. Accepts decoded ops over valid/ready,

---
 rtl/alu_issue_stage.sv | 260 ++++++++++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
//   ID->EX pipeline register sitting directly in front of the ALU.
//   - Accepts decoded ops over a valid/ready handshake.
//   - Resolves source operands with priority r0 > EX bypass > WB bypass > RF.
//   - Holds opcode/wordA/wordB/shamt/rd/wb_en stable at the ALU inputs
//     until the EX stage consumes them.
//   Optional feature macro: ALU_ISSUE_PERF_EN
//     adds o_perf_issued / o_perf_stall / o_perf_fwd 32-bit wrapping counters.
//   Reset: i_rst_n asserts asynchronously; its release is expected to be
//   synchronised to i_clk by the reset controller upstream.
// ---------------------------------------------------------------------------
module alu_issue_stage #(
    parameter int XLEN = 32,
    parameter int RW   = 5
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_flush,
    // decode side
    input  logic            i_dec_valid,
    output logic            o_dec_ready,
    input  logic [3:0]      i_dec_opcode,
    input  logic [RW-1:0]   i_dec_rs_a,
    input  logic [RW-1:0]   i_dec_rs_b,
    input  logic [RW-1:0]   i_dec_rd,
    input  logic            i_dec_wb_en,
    input  logic            i_dec_use_imm,
    input  logic [XLEN-1:0] i_dec_imm,
    input  logic [4:0]      i_dec_shamt,
    // register file read data (same cycle as decode)
    input  logic [XLEN-1:0] i_rf_data_a,
    input  logic [XLEN-1:0] i_rf_data_b,
    // writeback bypass
    input  logic            i_wb_en,
    input  logic [RW-1:0]   i_wb_rd,
    input  logic [XLEN-1:0] i_wb_data,
    // EX side
    input  logic [XLEN-1:0] i_ex_result,
    input  logic            i_ex_ready,
    output logic            o_ex_valid,
    output logic [3:0]      o_ex_opcode,
    output logic [XLEN-1:0] o_ex_wordA,
    output logic [XLEN-1:0] o_ex_wordB,
    output logic [4:0]      o_ex_shamt,
    output logic [RW-1:0]   o_ex_rd,
    output logic            o_ex_wb_en
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [31:0]     o_perf_issued,
    output logic [31:0]     o_perf_stall,
    output logic [31:0]     o_perf_fwd
`endif
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic               w_ex_valid;
    logic               w_dec_ready;
    logic               w_accept;
    logic               w_fire_ex;

    logic [3:0]         r_opcode;
    logic [XLEN-1:0]    r_word_a;
    logic [XLEN-1:0]    r_word_b;
    logic [4:0]         r_shamt;
    logic [RW-1:0]      r_rd;
    logic               r_wb_en;

    logic [XLEN-1:0]    w_opnd_a;
    logic [XLEN-1:0]    w_opnd_b;
    logic [XLEN-1:0]    w_word_b;
    logic               w_fwd_a;
    logic               w_fwd_b;
    logic               w_fwd_used;

    // True when source idx is satisfied by a bypass path rather than RF / r0.
    function automatic logic uses_bypass(
        input logic [RW-1:0] idx,
        input logic          ex_hit_en,
        input logic [RW-1:0] ex_rd,
        input logic          wb_en,
        input logic [RW-1:0] wb_rd
    );
        logic hit;
        hit = 1'b0;
        if (idx == {RW{1'b0}}) begin
            hit = 1'b0;
        end else if (ex_hit_en && (ex_rd == idx)) begin
            hit = 1'b1;
        end else if (wb_en && (wb_rd == idx)) begin
            hit = 1'b1;
        end else begin
            hit = 1'b0;
        end
        return hit;
    endfunction

    // Operand resolution: r0 reads zero, then EX result, then WB data, then RF.
    function automatic logic [XLEN-1:0] resolve_operand(
        input logic [RW-1:0]   idx,
        input logic [XLEN-1:0] rf_data,
        input logic            ex_hit_en,
        input logic [RW-1:0]   ex_rd,
        input logic [XLEN-1:0] ex_result,
        input logic            wb_en,
        input logic [RW-1:0]   wb_rd,
        input logic [XLEN-1:0] wb_data
    );
        logic [XLEN-1:0] val;
        val = {XLEN{1'b0}};
        if (idx == {RW{1'b0}}) begin
            val = {XLEN{1'b0}};
        end else if (ex_hit_en && (ex_rd == idx)) begin
            val = ex_result;
        end else if (wb_en && (wb_rd == idx)) begin
            val = wb_data;
        end else begin
            val = rf_data;
        end
        return val;
    endfunction

    // Handshake: a new op may enter only if the slot is free or draining this
    // cycle, and never while a flush is in progress.
    always_comb begin
        w_fire_ex   = w_ex_valid & i_ex_ready;
        w_dec_ready = ~i_flush & (~w_ex_valid | i_ex_ready);
        w_accept    = i_dec_valid & w_dec_ready;
    end

    // Operand muxing for the op currently presented by decode.
    always_comb begin
        w_opnd_a = resolve_operand(i_dec_rs_a, i_rf_data_a, w_ex_valid & r_wb_en,
                                   r_rd, i_ex_result, i_wb_en, i_wb_rd, i_wb_data);
        w_opnd_b = resolve_operand(i_dec_rs_b, i_rf_data_b, w_ex_valid & r_wb_en,
                                   r_rd, i_ex_result, i_wb_en, i_wb_rd, i_wb_data);
        w_fwd_a  = uses_bypass(i_dec_rs_a, w_ex_valid & r_wb_en, r_rd, i_wb_en, i_wb_rd);
        w_fwd_b  = uses_bypass(i_dec_rs_b, w_ex_valid & r_wb_en, r_rd, i_wb_en, i_wb_rd);
        if (i_dec_use_imm) begin
            w_word_b = i_dec_imm;
        end else begin
            w_word_b = w_opnd_b;
        end
        w_fwd_used = w_fwd_a | (~i_dec_use_imm & w_fwd_b);
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: flush wins, then a new load, then drain, else hold.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (i_flush) begin
                    w_state_nxt = ST_EMPTY;
                end else if (w_accept) begin
                    w_state_nxt = ST_FULL;
                end else begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (i_flush) begin
                    w_state_nxt = ST_EMPTY;
                end else if (w_accept) begin
                    w_state_nxt = ST_FULL;
                end else if (w_fire_ex) begin
                    w_state_nxt = ST_EMPTY;
                end else begin
                    w_state_nxt = ST_FULL;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // FSM output decode: the held op is valid exactly when the slot is FULL.
    always_comb begin
        w_ex_valid = 1'b0;
        case (r_state)
            ST_EMPTY: w_ex_valid = 1'b0;
            ST_FULL:  w_ex_valid = 1'b1;
            default:  w_ex_valid = 1'b0;
        endcase
    end

    // Payload registers: load only on accept so held values stay stable in stalls.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_opcode <= 4'h0;
            r_word_a <= {XLEN{1'b0}};
            r_word_b <= {XLEN{1'b0}};
            r_shamt  <= 5'd0;
            r_rd     <= {RW{1'b0}};
            r_wb_en  <= 1'b0;
        end else if (w_accept) begin
            r_opcode <= i_dec_opcode;
            r_word_a <= w_opnd_a;
            r_word_b <= w_word_b;
            r_shamt  <= i_dec_shamt;
            r_rd     <= i_dec_rd;
            r_wb_en  <= i_dec_wb_en;
        end
    end

`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] r_perf_issued;
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_fwd;

    // Performance counters; plain 32-bit adds wrap from all-ones to zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_perf_issued <= 32'd0;
            r_perf_stall  <= 32'd0;
            r_perf_fwd    <= 32'd0;
        end else begin
            if (w_accept) begin
                r_perf_issued <= r_perf_issued + 32'd1;
            end
            if (i_dec_valid && !w_dec_ready) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (w_accept && w_fwd_used) begin
                r_perf_fwd <= r_perf_fwd + 32'd1;
            end
        end
    end

    assign o_perf_issued = r_perf_issued;
    assign o_perf_stall  = r_perf_stall;
    assign o_perf_fwd    = r_perf_fwd;
`endif

    assign o_dec_ready = w_dec_ready;
    assign o_ex_valid  = w_ex_valid;
    assign o_ex_opcode = r_opcode;
    assign o_ex_wordA  = r_word_a;
    assign o_ex_wordB  = r_word_b;
    assign o_ex_shamt  = r_shamt;
    assign o_ex_rd     = r_rd;
    assign o_ex_wb_en  = r_wb_en;

endmodule

// File: tb/tb_alu_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_stage
//   Directed self-checking bench for alu_issue_stage (default build).
// ---------------------------------------------------------------------------
module tb_alu_issue_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        dec_valid;
    logic        dec_ready;
    logic [3:0]  dec_opcode;
    logic [4:0]  dec_rs_a;
    logic [4:0]  dec_rs_b;
    logic [4:0]  dec_rd;
    logic        dec_wb_en;
    logic        dec_use_imm;
    logic [31:0] dec_imm;
    logic [4:0]  dec_shamt;
    logic [31:0] rf_a;
    logic [31:0] rf_b;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] ex_result;
    logic        ex_ready;
    logic        ex_valid;
    logic [3:0]  ex_opcode;
    logic [31:0] ex_word_a;
    logic [31:0] ex_word_b;
    logic [4:0]  ex_shamt;
    logic [4:0]  ex_rd;
    logic        ex_wb_en;

    int checks;
    int errors;

    alu_issue_stage #(.XLEN(32), .RW(5)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_flush       (flush),
        .i_dec_valid   (dec_valid),
        .o_dec_ready   (dec_ready),
        .i_dec_opcode  (dec_opcode),
        .i_dec_rs_a    (dec_rs_a),
        .i_dec_rs_b    (dec_rs_b),
        .i_dec_rd      (dec_rd),
        .i_dec_wb_en   (dec_wb_en),
        .i_dec_use_imm (dec_use_imm),
        .i_dec_imm     (dec_imm),
        .i_dec_shamt   (dec_shamt),
        .i_rf_data_a   (rf_a),
        .i_rf_data_b   (rf_b),
        .i_wb_en       (wb_en),
        .i_wb_rd       (wb_rd),
        .i_wb_data     (wb_data),
        .i_ex_result   (ex_result),
        .i_ex_ready    (ex_ready),
        .o_ex_valid    (ex_valid),
        .o_ex_opcode   (ex_opcode),
        .o_ex_wordA    (ex_word_a),
        .o_ex_wordB    (ex_word_b),
        .o_ex_shamt    (ex_shamt),
        .o_ex_rd       (ex_rd),
        .o_ex_wb_en    (ex_wb_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a decoded op (stimulus only).
    task automatic set_op(input logic [3:0] op, input logic [4:0] ra, input logic [4:0] rb,
                          input logic [4:0] rd, input logic wbe, input logic use_imm,
                          input logic [31:0] imm, input logic [4:0] sh);
        dec_opcode  = op;
        dec_rs_a    = ra;
        dec_rs_b    = rb;
        dec_rd      = rd;
        dec_wb_en   = wbe;
        dec_use_imm = use_imm;
        dec_imm     = imm;
        dec_shamt   = sh;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; dec_valid = 1'b0; ex_ready = 1'b0;
        set_op(4'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 5'd0);
        rf_a = 32'h0; rf_b = 32'h0; wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
        ex_result = 32'h0;
        #12;
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h want 0", ex_valid); end
        checks++; if (ex_opcode !== 4'h0) begin errors++; $display("FAIL reset_opcode got %0h want 0", ex_opcode); end
        checks++; if (ex_word_a !== 32'h0 || ex_word_b !== 32'h0) begin errors++; $display("FAIL reset_words got %0h/%0h want 0/0", ex_word_a, ex_word_b); end
        checks++; if (ex_shamt !== 5'd0 || ex_rd !== 5'd0 || ex_wb_en !== 1'b0) begin errors++; $display("FAIL reset_misc got %0h/%0h/%0h want 0/0/0", ex_shamt, ex_rd, ex_wb_en); end
        checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0h want 1", dec_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_add_imm();
        set_op(4'h0, 5'd1, 5'd0, 5'd3, 1'b1, 1'b1, 32'h7, 5'd2);
        rf_a = 32'h5; ex_ready = 1'b1; dec_valid = 1'b1;
        #1;
        checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL add_ready got %0h want 1", dec_ready); end
        step();
        checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %0h want 1", ex_valid); end
        checks++; if (ex_opcode !== 4'h0 || ex_word_a !== 32'h5 || ex_word_b !== 32'h7) begin errors++; $display("FAIL add_payload got op=%0h a=%0h b=%0h want 0/5/7", ex_opcode, ex_word_a, ex_word_b); end
        checks++; if (ex_shamt !== 5'd2 || ex_rd !== 5'd3 || ex_wb_en !== 1'b1) begin errors++; $display("FAIL add_meta got %0h/%0h/%0h want 2/3/1", ex_shamt, ex_rd, ex_wb_en); end
    endtask

    task automatic test_back_to_back();
        // SUB rs_a=r3 (held rd=3): EX result beats stale RF; rs_b=r2 from WB.
        set_op(4'h1, 5'd3, 5'd2, 5'd5, 1'b1, 1'b0, 32'h0, 5'd0);
        rf_a = 32'h99; rf_b = 32'h20; ex_result = 32'hC;
        wb_en = 1'b1; wb_rd = 5'd2; wb_data = 32'h44;
        #1;
        checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %0h want 1", dec_ready); end
        step();
        checks++; if (ex_opcode !== 4'h1 || ex_word_a !== 32'hC) begin errors++; $display("FAIL b2b_ex_bypass got op=%0h a=%0h want 1/c", ex_opcode, ex_word_a); end
        checks++; if (ex_word_b !== 32'h44 || ex_rd !== 5'd5) begin errors++; $display("FAIL b2b_wb_bypass got b=%0h rd=%0h want 44/5", ex_word_b, ex_rd); end
        // rs_a=r0 reads zero despite RF; rs_b=r5 takes EX result.
        set_op(4'h2, 5'd0, 5'd5, 5'd4, 1'b1, 1'b0, 32'h0, 5'd0);
        rf_a = 32'hDEAD; rf_b = 32'h1; ex_result = 32'h31; wb_en = 1'b0;
        step();
        checks++; if (ex_word_a !== 32'h0 || ex_word_b !== 32'h31 || ex_valid !== 1'b1) begin errors++; $display("FAIL b2b_r0 got a=%0h b=%0h v=%0h want 0/31/1", ex_word_a, ex_word_b, ex_valid); end
    endtask

    task automatic test_bypass_priority();
        // WB r4=0xAA, EX holds rd=4 with result 0xBB: EX wins on both sources.
        set_op(4'h3, 5'd4, 5'd4, 5'd6, 1'b0, 1'b0, 32'h0, 5'd0);
        rf_a = 32'h11; rf_b = 32'h11;
        wb_en = 1'b1; wb_rd = 5'd4; wb_data = 32'hAA; ex_result = 32'hBB;
        step();
        checks++; if (ex_word_a !== 32'hBB || ex_word_b !== 32'hBB) begin errors++; $display("FAIL prio_ex_over_wb got %0h/%0h want bb/bb", ex_word_a, ex_word_b); end
        // Held rd=6 but wb_en=0: EX must not bypass; WB r6 wins, rs_b=r7 from RF.
        set_op(4'h4, 5'd6, 5'd7, 5'd7, 1'b1, 1'b0, 32'h0, 5'd0);
        rf_a = 32'h11; rf_b = 32'h22;
        wb_rd = 5'd6; wb_data = 32'h66; ex_result = 32'h77;
        step();
        checks++; if (ex_word_a !== 32'h66 || ex_word_b !== 32'h22) begin errors++; $display("FAIL prio_wb_over_rf got %0h/%0h want 66/22", ex_word_a, ex_word_b); end
        wb_en = 1'b0;
    endtask

    task automatic test_stall();
        ex_ready = 1'b0;
        set_op(4'h5, 5'd7, 5'd0, 5'd8, 1'b1, 1'b1, 32'h100, 5'd9);
        ex_result = 32'h700; rf_a = 32'h3;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL stall_ready cyc%0d got %0h want 0", i, dec_ready); end
            step();
            checks++; if (ex_valid !== 1'b1 || ex_opcode !== 4'h4 || ex_word_a !== 32'h66 || ex_word_b !== 32'h22 || ex_rd !== 5'd7) begin
                errors++; $display("FAIL stall_hold cyc%0d got v=%0h op=%0h a=%0h b=%0h rd=%0h want 1/4/66/22/7", i, ex_valid, ex_opcode, ex_word_a, ex_word_b, ex_rd);
            end
        end
        ex_ready = 1'b1;
        #1;
        checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got %0h want 1", dec_ready); end
        step();
        checks++; if (ex_opcode !== 4'h5 || ex_word_a !== 32'h700 || ex_word_b !== 32'h100 || ex_shamt !== 5'd9 || ex_rd !== 5'd8) begin
            errors++; $display("FAIL stall_load got op=%0h a=%0h b=%0h sh=%0h rd=%0h want 5/700/100/9/8", ex_opcode, ex_word_a, ex_word_b, ex_shamt, ex_rd);
        end
    endtask

    task automatic test_flush();
        // FULL, EX stalled, flush with a valid decode op.
        ex_ready = 1'b0; flush = 1'b1;
        set_op(4'h6, 5'd8, 5'd0, 5'd9, 1'b1, 1'b1, 32'h1, 5'd0);
        rf_a = 32'h88; ex_result = 32'h999;
        #1;
        checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %0h want 0", dec_ready); end
        step();
        checks++; if (ex_valid !== 1'b0 || ex_opcode !== 4'h5) begin errors++; $display("FAIL flush_empty got v=%0h op=%0h want 0/5", ex_valid, ex_opcode); end
        // EMPTY accepts even with EX not ready; stale held rd=8 must not bypass.
        flush = 1'b0;
        #1;
        checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL empty_ready got %0h want 1", dec_ready); end
        step();
        checks++; if (ex_valid !== 1'b1 || ex_opcode !== 4'h6 || ex_word_a !== 32'h88) begin errors++; $display("FAIL empty_load got v=%0h op=%0h a=%0h want 1/6/88", ex_valid, ex_opcode, ex_word_a); end
        // Flush while FULL and EX ready: held op drains, nothing new loaded.
        ex_ready = 1'b1; flush = 1'b1;
        set_op(4'h7, 5'd1, 5'd0, 5'd1, 1'b1, 1'b1, 32'h2, 5'd0);
        #1;
        checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL flush_fire_ready got %0h want 0", dec_ready); end
        step();
        checks++; if (ex_valid !== 1'b0 || ex_opcode !== 4'h6) begin errors++; $display("FAIL flush_fire got v=%0h op=%0h want 0/6", ex_valid, ex_opcode); end
        flush = 1'b0; dec_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        dec_valid = 1'b1; ex_ready = 1'b0;
        set_op(4'h3, 5'd1, 5'd0, 5'd2, 1'b1, 1'b1, 32'h55, 5'd4);
        rf_a = 32'h1234;
        step();
        dec_valid = 1'b0;
        checks++; if (ex_valid !== 1'b1 || ex_word_a !== 32'h1234) begin errors++; $display("FAIL pre_reset got v=%0h a=%0h want 1/1234", ex_valid, ex_word_a); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (ex_valid !== 1'b0 || ex_word_a !== 32'h0 || ex_opcode !== 4'h0 || ex_word_b !== 32'h0) begin
            errors++; $display("FAIL async_reset got v=%0h a=%0h op=%0h b=%0h want 0/0/0/0", ex_valid, ex_word_a, ex_opcode, ex_word_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL post_reset got %0h want 0", ex_valid); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_add_imm();
        test_back_to_back();
        test_bypass_priority();
        test_stall();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
